// File: rtl/osd_stm_arbiter_if.sv
// Request/trace bus between STM trace requesters and osd_stm_arbiter.
// The arbiter uses the slave modport; requester/STM models use the master modport.
interface osd_stm_arbiter_if #(
    parameter int NREQ = 4,
    parameter int XLEN = 64
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*16-1:0]   req_id;
    logic [NREQ*XLEN-1:0] req_value;
    logic [NREQ-1:0]      req_ready;
    logic                 trace_stall;
    logic                 trace_valid;
    logic [15:0]          trace_id;
    logic [XLEN-1:0]      trace_value;

    modport master (
        output req_valid, req_id, req_value, trace_stall,
        input  req_ready, trace_valid, trace_id, trace_value
    );

    modport slave (
        input  req_valid, req_id, req_value, trace_stall,
        output req_ready, trace_valid, trace_id, trace_value
    );
endinterface

// File: rtl/osd_stm_arbiter.sv
// Round-robin arbiter merging NREQ trace event sources onto one registered STM port.
// Optional per-requester saturating drop counters enabled by OSD_STM_ARB_DROPCNT_EN.
module osd_stm_arbiter #(
    parameter int NREQ = 4,
    parameter int XLEN = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    osd_stm_arbiter_if.slave     bus,
    input  logic [NREQ-1:0]      i_en_mask,
    input  logic                 i_drop_clr,
    output logic [NREQ*8-1:0]    o_drop_count
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic            r_traceValid;
    logic [15:0]     r_traceId;
    logic [XLEN-1:0] r_traceValue;

    logic [NREQ-1:0] w_elig;
    logic            w_grantValid;
    logic [PW-1:0]   w_grantIdx;
    logic [NREQ-1:0] w_ready;
    logic [15:0]     w_selId;
    logic [XLEN-1:0] w_selValue;

    assign w_elig = bus.req_valid & i_en_mask;

    // Search starts one past the last winner so every eligible source gets its turn.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_grantValid && w_elig[(int'(r_ptr) + k) % NREQ]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
        if (bus.trace_stall) begin
            w_grantValid = 1'b0;
        end
    end

    assign w_selId    = bus.req_id[16*int'(w_grantIdx) +: 16];
    assign w_selValue = bus.req_value[XLEN*int'(w_grantIdx) +: XLEN];

    // Disabled sources are always drained so they never back up behind the arbiter.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = ~i_en_mask[i] | (w_grantValid && (w_grantIdx == PW'(i)));
        end
    end

    assign bus.req_ready = i_rst_n ? w_ready : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr        <= PW'(NREQ - 1);
            r_traceValid <= 1'b0;
            r_traceId    <= '0;
            r_traceValue <= '0;
        end else begin
            r_traceValid <= w_grantValid;
            if (w_grantValid) begin
                r_ptr        <= w_grantIdx;
                r_traceId    <= w_selId;
                r_traceValue <= w_selValue;
            end
        end
    end

    assign bus.trace_valid = r_traceValid;
    assign bus.trace_id    = r_traceId;
    assign bus.trace_value = r_traceValue;

`ifdef OSD_STM_ARB_DROPCNT_EN
    logic [7:0] r_dropCnt [NREQ];

    // Clear takes priority over a discard landing in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_dropCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (i_drop_clr) begin
                    r_dropCnt[i] <= '0;
                end else if (!i_en_mask[i] && bus.req_valid[i] && (r_dropCnt[i] != 8'hFF)) begin
                    r_dropCnt[i] <= r_dropCnt[i] + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_dropOut
        assign o_drop_count[8*g +: 8] = r_dropCnt[g];
    end
`else
    logic w_unusedDropClr;
    assign w_unusedDropClr = i_drop_clr;
    assign o_drop_count    = '0;
`endif
endmodule

// File: tb/tb_osd_stm_arbiter.sv
// Directed, table-driven bench for osd_stm_arbiter (NREQ=4, XLEN=64).
// Drop-counter expectations follow OSD_STM_ARB_DROPCNT_EN as compiled.
module tb_osd_stm_arbiter;
    localparam int NREQ = 4;
    localparam int XLEN = 64;
`ifdef OSD_STM_ARB_DROPCNT_EN
    localparam bit DROPEN = 1'b1;
`else
    localparam bit DROPEN = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            resetN = 1'b0;
    logic [NREQ-1:0] enMask = '0;
    logic            dropClr = 1'b0;
    logic [NREQ*8-1:0] dropCount;

    int checks = 0;
    int errors = 0;

    osd_stm_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

    osd_stm_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .i_clk        (clock),
        .i_rst_n      (resetN),
        .bus          (bus),
        .i_en_mask    (enMask),
        .i_drop_clr   (dropClr),
        .o_drop_count (dropCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] en;
        logic       stall;
        logic [3:0] expReady;
        logic       expTv;
        int         expSrc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] en, logic st,
                                logic [3:0] rdy, logic tv, int src);
        vec_t r;
        r.valid = v; r.en = en; r.stall = st;
        r.expReady = rdy; r.expTv = tv; r.expSrc = src;
        return r;
    endfunction

    function automatic logic [15:0] idOf(int s);
        return 16'h0100 + 16'(s);
    endfunction

    function automatic logic [63:0] valueOf(int s);
        return 64'hCAFE_0000_0000_0000 | 64'(s);
    endfunction

    task automatic applyStimulus(logic [3:0] v, logic [3:0] en, logic st, logic clr);
        bus.req_valid   = v;
        enMask          = en;
        bus.trace_stall = st;
        dropClr         = clr;
    endtask

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkTrace(string tag, logic tv, int src);
        checkOutput({tag, " trace_valid"}, 64'(bus.trace_valid), 64'(tv));
        if (tv) begin
            checkOutput({tag, " trace_id"}, 64'(bus.trace_id), 64'(idOf(src)));
            checkOutput({tag, " trace_value"}, bus.trace_value, valueOf(src));
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_id[16*i +: 16]      = idOf(i);
            bus.req_value[XLEN*i +: XLEN] = valueOf(i);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Round robin over all four, then idle.
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'b0001, 0, -1));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'b0010, 1, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'b0100, 1, 1));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'b1000, 1, 2));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'b0001, 1, 3));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'b0010, 1, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'b0100, 1, 1));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 4'b1000, 1, 2));
        vecs.push_back(mk(4'b0000, 4'b1111, 0, 4'b0000, 1, 3));
        vecs.push_back(mk(4'b0000, 4'b1111, 0, 4'b0000, 0, -1));
        // Two requesters with a three-cycle stall.
        vecs.push_back(mk(4'b0101, 4'b1111, 0, 4'b0001, 0, -1));
        vecs.push_back(mk(4'b0101, 4'b1111, 0, 4'b0100, 1, 0));
        vecs.push_back(mk(4'b0101, 4'b1111, 0, 4'b0001, 1, 2));
        vecs.push_back(mk(4'b0101, 4'b1111, 1, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0101, 4'b1111, 1, 4'b0000, 0, -1));
        vecs.push_back(mk(4'b0101, 4'b1111, 1, 4'b0000, 0, -1));
        vecs.push_back(mk(4'b0101, 4'b1111, 0, 4'b0100, 0, -1));
        vecs.push_back(mk(4'b0101, 4'b1111, 0, 4'b0001, 1, 2));
        vecs.push_back(mk(4'b0000, 4'b1111, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0000, 4'b1111, 0, 4'b0000, 0, -1));
        // Requester 2 disabled: always ready, never granted, even under stall.
        vecs.push_back(mk(4'b0100, 4'b1011, 0, 4'b0100, 0, -1));
        vecs.push_back(mk(4'b0100, 4'b1011, 1, 4'b0100, 0, -1));
        vecs.push_back(mk(4'b1111, 4'b1011, 0, 4'b0110, 0, -1));
        vecs.push_back(mk(4'b1111, 4'b1011, 0, 4'b1100, 1, 1));
        vecs.push_back(mk(4'b1111, 4'b1011, 0, 4'b0101, 1, 3));
        vecs.push_back(mk(4'b1111, 4'b1011, 1, 4'b0100, 1, 0));
        vecs.push_back(mk(4'b0000, 4'b1011, 0, 4'b0100, 0, -1));
        // Requester 2 granted, then disabled while still requesting.
        vecs.push_back(mk(4'b1100, 4'b1111, 0, 4'b0100, 0, -1));
        vecs.push_back(mk(4'b1100, 4'b1011, 0, 4'b1100, 1, 2));
        vecs.push_back(mk(4'b1100, 4'b1011, 0, 4'b1100, 1, 3));
        vecs.push_back(mk(4'b0000, 4'b1111, 0, 4'b0000, 1, 3));
        vecs.push_back(mk(4'b0000, 4'b1111, 0, 4'b0000, 0, -1));

        #1;
        checkOutput("reset trace_valid", 64'(bus.trace_valid), 64'd0);
        checkOutput("reset trace_id", 64'(bus.trace_id), 64'd0);
        checkOutput("reset trace_value", bus.trace_value, 64'd0);
        checkOutput("reset req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("reset drop_count", 64'(dropCount), 64'd0);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clock);
            applyStimulus(vecs[n].valid, vecs[n].en, vecs[n].stall, 1'b0);
            #1;
            checkOutput($sformatf("row%0d req_ready", n), 64'(bus.req_ready), 64'(vecs[n].expReady));
            checkTrace($sformatf("row%0d", n), vecs[n].expTv, vecs[n].expSrc);
        end

        // Clear coincident with a discard, then a single counted discard.
        @(negedge clock);
        applyStimulus(4'b0100, 4'b1011, 1'b0, 1'b1);
        @(negedge clock);
        applyStimulus(4'b0100, 4'b1011, 1'b0, 1'b0);
        #1;
        checkOutput("drop clr coincident", 64'(dropCount), 64'd0);
        @(negedge clock);
        applyStimulus(4'b0000, 4'b1011, 1'b0, 1'b0);
        #1;
        checkOutput("drop count one", 64'(dropCount), DROPEN ? 64'h0001_0000 : 64'd0);

        // Sustained discards saturate the counter.
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            applyStimulus(4'b0100, 4'b1011, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("sat%0d req_ready", c), 64'(bus.req_ready), 64'h4);
            checkOutput($sformatf("sat%0d trace_valid", c), 64'(bus.trace_valid), 64'd0);
        end
        @(negedge clock);
        applyStimulus(4'b0000, 4'b1011, 1'b0, 1'b1);
        #1;
        checkOutput("drop saturated", 64'(dropCount), DROPEN ? 64'h00FF_0000 : 64'd0);
        @(negedge clock);
        applyStimulus(4'b0000, 4'b1011, 1'b0, 1'b0);
        #1;
        checkOutput("drop after clr", 64'(dropCount), 64'd0);

        // Reset hitting a live output event.
        @(negedge clock);
        applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0);
        @(negedge clock);
        #1;
        checkTrace("pre-reset", 1'b1, 0);
        resetN = 1'b0;
        #1;
        checkOutput("async trace_valid", 64'(bus.trace_valid), 64'd0);
        checkOutput("async trace_id", 64'(bus.trace_id), 64'd0);
        checkOutput("async trace_value", bus.trace_value, 64'd0);
        checkOutput("async req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clock);
        resetN = 1'b1;
        applyStimulus(4'b1000, 4'b1111, 1'b0, 1'b0);
        #1;
        checkOutput("post-reset req_ready", 64'(bus.req_ready), 64'h8);
        checkOutput("post-reset trace_valid", 64'(bus.trace_valid), 64'd0);
        @(negedge clock);
        applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0);
        #1;
        checkOutput("post-reset wrap ready", 64'(bus.req_ready), 64'h1);
        checkTrace("post-reset g3", 1'b1, 3);
        @(negedge clock);
        applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
        #1;
        checkTrace("post-reset g0", 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
